// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch and data ports
module mem_port_arbiter #(
  parameter int MEM_LAT  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        grant_d
);
  localparam logic [3:0] LAT = 4'(MEM_LAT);
  localparam logic [3:0] MW  = 4'(MAX_WAIT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [3:0] lat_cnt, starve_cnt;
  logic win_f, win_d, grant;
  // arbitration (fetch only wins a contested slot once starved) and next state
  always_comb begin
    win_f = if_req && (!d_req || starve_cnt == MW);
    win_d = d_req && !win_f;
    grant = state == IDLE && (win_f || win_d);
    state_n = state == IDLE  ? (grant ? ISSUE : IDLE) :
              state == ISSUE ? WAIT :
              state == WAIT  ? (lat_cnt == 4'd1 ? RESP : WAIT) : IDLE;
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  // registered datapath: latch winner at grant, strobe memory in ISSUE, capture read data on the last WAIT cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      if_ack <= 1'b0;
      if_rdata <= '0;
      d_ack <= 1'b0;
      d_rdata <= '0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_be <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      busy <= 1'b0;
      grant_d <= 1'b0;
      lat_cnt <= '0;
      starve_cnt <= '0;
    end else begin
      mem_en <= grant;
      if_ack <= 1'b0;
      d_ack <= 1'b0;
      busy <= state_n != IDLE;
      if (grant) begin
        grant_d <= win_d;
        mem_we <= win_d && d_we;
        mem_be <= win_d && d_we ? d_be : 4'hF;
        mem_addr <= win_d ? d_addr : if_addr;
        mem_wdata <= win_d ? d_wdata : '0;
      end
      if (state == IDLE)
        starve_cnt <= win_f ? '0 : (if_req && win_d && starve_cnt != MW) ? starve_cnt + 4'd1 : starve_cnt;
      if (state == ISSUE) lat_cnt <= LAT;
      if (state == WAIT) begin
        lat_cnt <= lat_cnt - 4'd1;
        if (lat_cnt == 4'd1) begin
          if_ack <= !grant_d;
          d_ack <= grant_d;
          if_rdata <= grant_d ? if_rdata : mem_rdata;
          d_rdata <= grant_d ? (mem_we ? '0 : mem_rdata) : d_rdata;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, latency and reset abort
module tb_mem_port_arbiter;
  logic clk = 0, reset = 1;
  logic if_req = 0, d_req = 0, d_req3 = 0, d_we = 0;
  logic [3:0] d_be = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0;
  logic if_ack, d_ack, mem_en, mem_we, busy, grant_d;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_be;
  logic if_ack3, d_ack3, mem_en3, mem_we3, busy3, grant_d3;
  logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
  logic [3:0] mem_be3;
  logic [31:0] a1, a3 [3];
  int vec = 0, mis = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mf(input logic [31:0] a);
    return a == 32'h4 ? 32'h0010_0093 : a == 32'h200 ? 32'h1234_5678 : {a[15:0] ^ 16'hA5A5, a[15:0]};
  endfunction

  always @(posedge clk) begin
    a1 <= mem_addr;
    a3[0] <= mem_addr3;
    a3[1] <= a3[0];
    a3[2] <= a3[1];
  end
  assign mem_rdata = mf(a1);
  assign mem_rdata3 = mf(a3[2]);

  mem_port_arbiter #(.MEM_LAT(1), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .grant_d(grant_d));

  mem_port_arbiter #(.MEM_LAT(3), .MAX_WAIT(4)) dut3 (
    .clk(clk), .reset(reset), .if_req(1'b0), .if_addr(if_addr), .if_ack(if_ack3), .if_rdata(if_rdata3),
    .d_req(d_req3), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack3), .d_rdata(d_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_be(mem_be3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .busy(busy3), .grant_d(grant_d3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input bit dside, output int n, output int en_n, output int busy_n, output int oth,
                          output logic [31:0] rd, output logic [31:0] ea, output logic [31:0] ewd,
                          output logic ewe, output logic [3:0] ebe);
    n = 0; en_n = 0; busy_n = 0; oth = 0;
    ea = 'x; ewd = 'x; ewe = 'x; ebe = 'x;
    do begin
      tick();
      n++;
      en_n += int'(mem_en);
      busy_n += int'(busy);
      oth += int'(dside ? if_ack : d_ack);
      if (mem_en) begin ea = mem_addr; ewd = mem_wdata; ewe = mem_we; ebe = mem_be; end
    end while (!(dside ? d_ack : if_ack) && n < 50);
    rd = dside ? d_rdata : if_rdata;
  endtask

  task automatic wait_any(output logic who_d, output int n);
    n = 0;
    do begin tick(); n++; end while (!(if_ack || d_ack) && n < 50);
    who_d = d_ack;
  endtask

  initial begin
    int n, en_n, busy_n, oth;
    logic [31:0] rd, ea, ewd;
    logic ewe, who;
    logic [3:0] ebe;
    logic exp_seq [6] = '{1, 1, 1, 1, 0, 1};
    repeat (2) tick();
    chk("rst_outs", {if_ack, d_ack, mem_en, mem_we, busy, grant_d}, 0);
    chk("rst_addr", mem_addr, 0);
    reset = 0;
    tick();
    if_req = 1; if_addr = 32'h4;
    wait_ack(0, n, en_n, busy_n, oth, rd, ea, ewd, ewe, ebe);
    if_req = 0;
    chk("fetch_lat", n, 3);
    chk("fetch_en_cycles", en_n, 1);
    chk("fetch_busy_cycles", busy_n, 3);
    chk("fetch_addr", ea, 32'h4);
    chk("fetch_we_be", {ewe, ebe}, 5'h0F);
    chk("fetch_rdata", rd, 32'h0010_0093);
    chk("fetch_grant", grant_d, 0);
    tick();
    chk("fetch_ack_pulse", {if_ack, busy}, 0);
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    wait_ack(1, n, en_n, busy_n, oth, rd, ea, ewd, ewe, ebe);
    d_req = 0; d_we = 0;
    chk("store_lat", n, 3);
    chk("store_en_cycles", en_n, 1);
    chk("store_we_be", {ewe, ebe}, 5'h13);
    chk("store_addr", ea, 32'h100);
    chk("store_wdata", ewd, 32'hDEAD_BEEF);
    chk("store_rdata", rd, 0);
    chk("store_no_if_ack", oth, 0);
    chk("store_grant", grant_d, 1);
    tick();
    d_req = 1; d_addr = 32'h300; if_req = 1; if_addr = 32'h8;
    wait_ack(1, n, en_n, busy_n, oth, rd, ea, ewd, ewe, ebe);
    d_req = 0;
    chk("both_data_first", n, 3);
    chk("both_data_rdata", rd, mf(32'h300));
    chk("both_load_be", {ewe, ebe}, 5'h0F);
    chk("both_no_if_ack", oth, 0);
    wait_ack(0, n, en_n, busy_n, oth, rd, ea, ewd, ewe, ebe);
    if_req = 0;
    chk("both_fetch_next", n, 4);
    chk("both_fetch_rdata", rd, mf(32'h8));
    chk("both_fetch_grant", grant_d, 0);
    tick();
    d_req = 1; d_addr = 32'h10; if_req = 1; if_addr = 32'h20;
    for (int i = 0; i < 6; i++) begin
      wait_any(who, n);
      chk($sformatf("starve_seq_%0d", i), who, exp_seq[i]);
      chk($sformatf("starve_lat_%0d", i), n, i == 0 ? 3 : 4);
    end
    d_req = 0; if_req = 0;
    tick();
    d_req3 = 1; d_we = 0; d_addr = 32'h200;
    n = 0;
    oth = 0;
    do begin tick(); n++; oth += int'(mem_en3); end while (!d_ack3 && n < 50);
    d_req3 = 0;
    chk("lat3_cycles", n, 5);
    chk("lat3_en_cycles", oth, 1);
    chk("lat3_rdata", d_rdata3, 32'h1234_5678);
    chk("lat3_no_if_ack", if_ack3, 0);
    tick();
    chk("lat3_ack_pulse", d_ack3, 0);
    d_req = 1; d_we = 0; d_addr = 32'h40;
    tick();
    chk("abort_issue_en", mem_en, 1);
    tick();
    chk("abort_wait_busy", {busy, mem_en}, 2'b10);
    reset = 1; d_req = 0;
    tick();
    chk("abort_outs", {if_ack, d_ack, mem_en, mem_we, busy, grant_d}, 0);
    chk("abort_addr", mem_addr, 0);
    chk("abort_rdata", d_rdata, 0);
    reset = 0;
    oth = 0;
    repeat (4) begin tick(); oth += int'(d_ack); end
    chk("abort_no_ack", oth, 0);
    if_req = 1; if_addr = 32'hC;
    wait_ack(0, n, en_n, busy_n, oth, rd, ea, ewd, ewe, ebe);
    if_req = 0;
    chk("post_rst_lat", n, 3);
    chk("post_rst_rdata", rd, mf(32'hC));
    chk("post_rst_addr", ea, 32'hC);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
